// File: rtl/display_scheduler.sv
// Purpose: arbitrates two binary sources (A entry, B result), converts the winner to 4 BCD digits, holds them for the digit mux.
// Latency: accept edge E0, 14 shift edges E1..E14, digits + update pulse at E15; next accept no earlier than E16.
// Backpressure: a_ready/b_ready are high only in IDLE for the granted source; senders hold valid/data until accepted.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   a_valid/a_data    source A offer; a_ready grants it this cycle
//   b_valid/b_data    source B offer; b_ready grants it this cycle
//   blank_en          leading-zero blanking enable, sampled on the DONE edge
//   number_3..0       registered digits, number_3 leftmost
//   update            one-cycle pulse when new digits land
//   busy              conversion in flight (CONVERT or DONE)
//   owner             source of the displayed value (0=A, 1=B)

module display_scheduler #(
    parameter int         WIDTH      = 14,
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter logic [3:0] ERR_CODE   = 4'hE,
    parameter int         MAX_VALUE  = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             blank_en,
    output logic [3:0]       number_0,
    output logic [3:0]       number_1,
    output logic [3:0]       number_2,
    output logic [3:0]       number_3,
    output logic             update,
    output logic             busy,
    output logic             owner
);

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] bin_q;
    logic [15:0]      bcd_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             src_q;
    // Set when B won the last grant; resets to 1 so A wins the first contention.
    logic             last_b_q;

    logic             grant_a, grant_b, accept;
    logic [WIDTH-1:0] sel_dat;
    logic [14:0]      bcd_adj;
    logic             blank_3, blank_2, blank_1;

    // Round-robin: on contention the source not granted last wins.
    always_comb begin
        grant_b = b_valid && (!a_valid || !last_b_q);
        grant_a = a_valid && !grant_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
                if (grant_a || grant_b) begin
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q == CW'(1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign accept  = a_ready || b_ready;
    assign sel_dat = b_ready ? b_data : a_data;
    assign busy    = (state != IDLE);

    // Add-3 correction before each shift. The top nibble's carry out is
    // shifted away, so only its low three bits are kept (mod-8 add);
    // values that would need it are flagged out of range anyway.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 3; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
        bcd_adj[14:12] = bcd_q[14:12] + ((bcd_q[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    end

    // Leading-zero blanking walks down from the thousands digit; ones never blanks.
    always_comb begin
        blank_3 = blank_en && (bcd_q[15:12] == 4'd0);
        blank_2 = blank_3 && (bcd_q[11:8] == 4'd0);
        blank_1 = blank_2 && (bcd_q[7:4] == 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            src_q    <= 1'b0;
            last_b_q <= 1'b1;
            number_0 <= 4'd0;
            number_1 <= 4'd0;
            number_2 <= 4'd0;
            number_3 <= 4'd0;
            update   <= 1'b0;
            owner    <= 1'b0;
        end else begin
            update <= 1'b0;
            if (accept) begin
                bin_q    <= sel_dat;
                bcd_q    <= '0;
                cnt_q    <= CW'(WIDTH);
                ovf_q    <= (sel_dat > MAX_V);
                src_q    <= b_ready;
                last_b_q <= b_ready;
            end else if (state == CONVERT) begin
                bcd_q <= {bcd_adj, bin_q[WIDTH-1]};
                bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
            end else if (state == DONE) begin
                update <= 1'b1;
                owner  <= src_q;
                if (ovf_q) begin
                    number_0 <= ERR_CODE;
                    number_1 <= ERR_CODE;
                    number_2 <= ERR_CODE;
                    number_3 <= ERR_CODE;
                end else begin
                    number_0 <= bcd_q[3:0];
                    number_1 <= blank_1 ? BLANK_CODE : bcd_q[7:4];
                    number_2 <= blank_2 ? BLANK_CODE : bcd_q[11:8];
                    number_3 <= blank_3 ? BLANK_CODE : bcd_q[15:12];
                end
            end
        end
    end

endmodule
